leiwand_rv32_wb_uart_tx: RTL and testbench

//  Wishbone slave UART transmitter on the core data bus, next to internal_sram/internal_rom.

---
 rtl/leiwand_rv32_wb_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_leiwand_rv32_wb_uart_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Wishbone slave UART transmitter: bus writes are queued in a byte FIFO and sent 8N1 on uart_tx.
// Latency: ack and read data one cycle after accept; a byte pushed into an idle, empty FIFO starts its start bit two clocks after accept.
// Backpressure: the bus is never stalled; a push into a full FIFO is dropped and latches the sticky overflow flag.
module leiwand_rv32_wb_uart_tx #(
  parameter int          MEM_WIDTH   = 32,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           wb_addr,
  input  logic [MEM_WIDTH-1:0] wb_data_in,
  output logic [MEM_WIDTH-1:0] wb_data_out,
  input  logic                 wb_we,
  input  logic                 wb_stb,
  output logic                 wb_ack,
  input  logic                 wb_cyc,
  output logic                 wb_stall,
  output logic                 uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;
  logic [15:0]          r_div;
  logic                 r_ack;
  logic [MEM_WIDTH-1:0] r_data_out;
  state_t               r_state;
  logic [15:0]          r_cnt;
  logic [15:0]          r_div_lat;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_tx;

  logic                 w_accept, w_push_req, w_push, w_pop;
  logic                 w_empty, w_full, w_bit_end, w_busy, w_ovf_set, w_status_rd;
  logic [MEM_WIDTH-1:0] w_rd_data;
  logic                 w_unused_data;

  // A held strobe only counts again once the previous ack has dropped.
  assign w_accept    = wb_stb & wb_cyc & ~r_ack;
  assign w_push_req  = w_accept & wb_we & (wb_addr == 2'd0);
  assign w_status_rd = w_accept & ~wb_we & (wb_addr == 2'd1);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_bit_end   = (r_cnt == r_div_lat);
  assign w_busy      = (r_state != S_IDLE);
  // The FSM takes the next byte from IDLE, or straight from the last stop-bit clock for gapless frames.
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  // A pop in the same cycle frees a slot, so a push at full is still taken then.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_ovf_set   = w_push_req & w_full & ~w_pop;
  assign w_unused_data = ^wb_data_in[MEM_WIDTH-1:16];

  assign wb_ack      = r_ack;
  assign wb_data_out = r_data_out;
  assign wb_stall    = 1'b0;
  assign uart_tx     = r_tx;

  // Register read multiplexer.
  always_comb begin
    w_rd_data = '0;
    case (wb_addr)
      2'd1: begin
        w_rd_data[0]      = w_busy;
        w_rd_data[1]      = w_full;
        w_rd_data[2]      = w_empty;
        w_rd_data[3]      = r_overflow;
        w_rd_data[8 +: CW] = r_count;
      end
      2'd2:    w_rd_data[15:0] = r_div;
      default: w_rd_data = '0;
    endcase
  end

  // Bus response, BAUD register and sticky overflow; data_out stays 0 unless acking a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_data_out <= '0;
      r_div      <= DEFAULT_DIV;
      r_overflow <= 1'b0;
    end else begin
      r_ack      <= w_accept;
      r_data_out <= (w_accept & ~wb_we) ? w_rd_data : '0;
      if (w_accept & wb_we & (wb_addr == 2'd2))
        r_div <= wb_data_in[15:0];
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (w_status_rd)
        r_overflow <= 1'b0;
    end
  end

  // FIFO storage; reset only clears the pointers, stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= wb_data_in[7:0];
  end

  // FIFO pointers and fill count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmit FSM with registered line output; DIV is latched per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_div_lat <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_div_lat <= r_div;
            r_cnt     <= '0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift   <= r_mem[r_rd_ptr];
              r_div_lat <= r_div;
              r_tx      <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_uart_tx.sv
// Directed bench for the Wishbone UART transmitter.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
// Serial frames are decoded by a sampling receiver task and compared against hand-computed bytes.
module tb_leiwand_rv32_wb_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_addr;
  logic [31:0] wb_data_in;
  logic [31:0] wb_data_out;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_cyc;
  logic        wb_stall;
  logic        uart_tx;

  int n_tests = 0;
  int n_fail  = 0;

  leiwand_rv32_wb_uart_tx dut (
    .clk         (clk),
    .reset       (reset),
    .wb_addr     (wb_addr),
    .wb_data_in  (wb_data_in),
    .wb_data_out (wb_data_out),
    .wb_we       (wb_we),
    .wb_stb      (wb_stb),
    .wb_ack      (wb_ack),
    .wb_cyc      (wb_cyc),
    .wb_stall    (wb_stall),
    .uart_tx     (uart_tx)
  );

  always #5 clk = ~clk;

  // One bus access: drive on a falling edge, accepted on the next rising edge, response read one cycle later.
  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output bit ack_ok);
    logic pre;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_data_in = wd;
    pre = wb_ack;
    @(negedge clk);
    ack_ok = (pre === 1'b0) && (wb_ack === 1'b1);
    rd = wb_data_out;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  // Receive one frame at d+1 clocks per bit; needs bit0 = 1 so the start-bit length is measurable.
  task automatic rx_frame(input int d, output logic [7:0] b, output int slen, output bit ok);
    int w;
    ok = 1'b1; b = '0; slen = 0; w = 0;
    do begin
      @(negedge clk); w++;
    end while (uart_tx !== 1'b0 && w < 3000);
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    while (uart_tx === 1'b0 && slen < 1000) begin
      slen++; @(negedge clk);
    end
    repeat (d / 2) @(negedge clk);
    b[0] = uart_tx;
    for (int i = 1; i < 8; i++) begin
      repeat (d + 1) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (d + 1) @(negedge clk);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; bit ok;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", uart_tx); end
    n_tests++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", wb_ack); end
    n_tests++; if (wb_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", wb_data_out); end
    n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", wb_stall); end
    bus(1'b0, 2'd1, 32'h0, rd, ok);
    n_tests++; if (!ok || rd !== 32'h0000_0004) begin n_fail++; $display("FAIL reset_status got %h ack_ok %0d want 00000004", rd, ok); end
    bus(1'b0, 2'd2, 32'h0, rd, ok);
    n_tests++; if (!ok || rd !== 32'h0000_0003) begin n_fail++; $display("FAIL reset_baud got %h want 00000003", rd); end
  endtask

  // DIV=3, byte 0x55: 4 low, bits 1,0,1,0,1,0,1,0 at 4 clocks each, 4 high.
  task automatic test_single_frame();
    logic [31:0] rd, rd_mid; bit ok, ok_mid;
    logic        want;
    logic [7:0]  byte_v;
    int          errs;
    byte_v = 8'h55; errs = 0;
    bus(1'b1, 2'd0, 32'h0000_0055, rd, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tx_write_ack got not-acked-after-1-clk want acked"); end
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx_latency got %b want 1 before start", uart_tx); end
    fork
      begin
        for (int k = 1; k <= 40; k++) begin
          @(negedge clk);
          if (k <= 4)       want = 1'b0;
          else if (k <= 36) want = byte_v[(k - 5) / 4];
          else              want = 1'b1;
          if (uart_tx !== want) errs++;
        end
      end
      begin
        repeat (9) @(negedge clk);
        bus(1'b0, 2'd1, 32'h0, rd_mid, ok_mid);
      end
    join
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL tx_pattern_55 got %0d wrong samples want 0", errs); end
    n_tests++; if (rd_mid !== 32'h0000_0005) begin n_fail++; $display("FAIL status_busy got %h want 00000005", rd_mid); end
    @(negedge clk);
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after got %b want 1", uart_tx); end
    bus(1'b0, 2'd1, 32'h0, rd, ok);
    n_tests++; if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL status_after_frame got %h want 00000004", rd); end
  endtask

  // 18 writes at DIV=3: byte 0 goes straight into the shifter, 1..16 fill the FIFO, byte 17 overflows.
  task automatic test_overflow_order();
    logic [31:0] rd1, rd2, rd; bit ok;
    logic [7:0]  got [17];
    bit          fok [17];
    int          sl;
    int          lows;
    fork
      begin
        for (int i = 0; i < 17; i++) rx_frame(3, got[i], sl, fok[i]);
      end
      begin
        for (int i = 0; i < 18; i++) bus(1'b1, 2'd0, 32'((i << 1) | 1), rd, ok);
        bus(1'b0, 2'd1, 32'h0, rd1, ok);
        bus(1'b0, 2'd1, 32'h0, rd2, ok);
      end
    join
    n_tests++; if (rd1 !== 32'h0000_100B) begin n_fail++; $display("FAIL status_full_ovf got %h want 0000100b", rd1); end
    n_tests++; if (rd2 !== 32'h0000_1003) begin n_fail++; $display("FAIL status_ovf_cleared got %h want 00001003", rd2); end
    for (int i = 0; i < 17; i++) begin
      n_tests++;
      if (!fok[i] || got[i] !== 8'((i << 1) | 1)) begin
        n_fail++; $display("FAIL order_byte%0d got %h framing_ok %0d want %h", i, got[i], fok[i], 8'((i << 1) | 1));
      end
    end
    lows = 0;
    repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    n_tests++; if (lows != 0) begin n_fail++; $display("FAIL dropped_byte_sent got %0d low samples want 0", lows); end
  endtask

  task automatic test_idle_bus();
    logic [31:0] rd; bit ok;
    logic        acks [4];
    logic [31:0] dats [4];
    int          errs;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b0; wb_addr = 2'(i); wb_we = i[2]; wb_data_in = 32'hDEAD_0000 | 32'(i);
      if (wb_ack !== 1'b0 || wb_data_out !== 32'h0) errs++;
    end
    @(negedge clk);
    if (wb_ack !== 1'b0 || wb_data_out !== 32'h0) errs++;
    wb_cyc = 1'b0;
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL unselected_quiet got %0d bad cycles want 0", errs); end
    bus(1'b0, 2'd3, 32'h0, rd, ok);
    n_tests++; if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL off3_read got %h ack_ok %0d want 0 acked", rd, ok); end
    bus(1'b1, 2'd3, 32'hFFFF_FFFF, rd, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL off3_write_ack got not-acked want acked"); end
    bus(1'b1, 2'd1, 32'hFFFF_FFFF, rd, ok);
    bus(1'b0, 2'd0, 32'h0, rd, ok);
    n_tests++; if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL txdata_read got %h want 0 acked", rd); end
    bus(1'b0, 2'd1, 32'h0, rd, ok);
    n_tests++; if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL status_after_ignored got %h want 00000004", rd); end
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); acks[k] = wb_ack; dats[k] = wb_data_out;
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;
    n_tests++;
    if ({acks[0], acks[1], acks[2], acks[3]} !== 4'b1010 || dats[0] !== 32'h4 || dats[1] !== 32'h0 || dats[2] !== 32'h4) begin
      n_fail++; $display("FAIL held_stb got ack %b%b%b%b data %h %h %h want ack 1010 data 4 0 4",
                         acks[0], acks[1], acks[2], acks[3], dats[0], dats[1], dats[2]);
    end
  endtask

  // BAUD write during a DIV=3 frame only affects the following frame.
  task automatic test_baud_midframe();
    logic [31:0] rd, rdb; bit ok;
    logic [7:0]  b1, b2;
    int          s1, s2;
    bit          f1, f2;
    fork
      begin
        rx_frame(3, b1, s1, f1);
        rx_frame(7, b2, s2, f2);
      end
      begin
        bus(1'b1, 2'd0, 32'h0000_00A5, rd, ok);
        bus(1'b1, 2'd2, 32'h0000_0007, rd, ok);
        bus(1'b1, 2'd0, 32'h0000_003D, rd, ok);
        bus(1'b0, 2'd2, 32'h0, rdb, ok);
      end
    join
    n_tests++; if (rdb !== 32'h0000_0007) begin n_fail++; $display("FAIL baud_read got %h want 00000007", rdb); end
    n_tests++; if (s1 != 4 || !f1 || b1 !== 8'hA5) begin n_fail++; $display("FAIL frame_old_div got start %0d byte %h want start 4 byte a5", s1, b1); end
    n_tests++; if (s2 != 8 || !f2 || b2 !== 8'h3D) begin n_fail++; $display("FAIL frame_new_div got start %0d byte %h want start 8 byte 3d", s2, b2); end
  endtask

  // Reset while byte 0xF0 is on its data bit 3 (a zero), with two more bytes queued.
  task automatic test_reset_midframe();
    logic [31:0] rd; bit ok;
    int          lows;
    repeat (20) @(negedge clk);
    bus(1'b1, 2'd2, 32'h0000_0003, rd, ok);
    repeat (4) @(negedge clk);
    bus(1'b1, 2'd0, 32'h0000_00F0, rd, ok);
    bus(1'b1, 2'd0, 32'h0000_0011, rd, ok);
    bus(1'b1, 2'd0, 32'h0000_0022, rd, ok);
    repeat (14) @(negedge clk);
    n_tests++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL data_bit3 got %b want 0", uart_tx); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL tx_after_reset got %b want 1", uart_tx); end
    bus(1'b0, 2'd1, 32'h0, rd, ok);
    n_tests++; if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL status_after_reset got %h want 00000004", rd); end
    bus(1'b0, 2'd2, 32'h0, rd, ok);
    n_tests++; if (rd !== 32'h0000_0003) begin n_fail++; $display("FAIL baud_after_reset got %h want 00000003", rd); end
    lows = 0;
    repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    n_tests++; if (lows != 0) begin n_fail++; $display("FAIL frames_after_reset got %0d low samples want 0", lows); end
  endtask

  initial begin
    reset = 1'b1; wb_addr = '0; wb_data_in = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow_order();
    test_idle_bus();
    test_baud_midframe();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
